// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } rx_state_t;

  localparam int unsigned SYNC_STAGES = 2;

  // Counter width for a value range of 0..n-1, never below one bit.
  function automatic int unsigned width_of(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO; a push while full is accepted only alongside a pop.
module uart_rx_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CntW'(DEPTH));
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);
  assign dout_o  = mem_q[rd_ptr_q];

  always_comb begin
    cnt_d = cnt_q;
    if (push_ok && !pop_ok) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (pop_ok && !push_ok) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, mid-bit sampling FSM, per-character
// parity/framing flags and a small receive FIFO with sticky overrun.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_i,
  input  logic                 clr_rdy_i,
  input  logic                 clr_ovr_i,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 rdy_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam int unsigned CntW = width_of(CLKS_PER_BIT);
  localparam int unsigned IdxW = width_of(DATA_BITS);
  localparam int unsigned EntW = DATA_BITS + 2;

  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntMid  = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_BITS - 1);
  localparam logic            StopLast = 1'(STOP_BITS - 1);
  localparam logic            ParOdd   = 1'(PARITY_ODD);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;

  rx_state_t              state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic                   stop_q, stop_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic                   ovr_q, ovr_d;

  logic                   bit_tick;
  logic                   push;
  logic [EntW-1:0]        push_entry;
  logic [EntW-1:0]        head;
  logic                   fifo_empty, fifo_full;

  // Synchroniser resets to idle-high so reset can never look like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
    end
  end

  assign rx_s     = sync_q[SYNC_STAGES-1];
  assign bit_tick = (cnt_q == CntLast);

  always_comb begin
    state_d    = state_q;
    cnt_d      = bit_tick ? '0 : cnt_q + CntW'(1);
    idx_d      = idx_q;
    stop_d     = stop_q;
    shreg_d    = shreg_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    push       = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d  = '0;
        idx_d  = '0;
        stop_d = 1'b0;
        perr_d = 1'b0;
        ferr_d = 1'b0;
        if (!rx_s) begin
          state_d = StStart;
        end
      end
      StStart: begin
        // Half-bit offset here puts every later sample mid-bit.
        if (cnt_q == CntMid) begin
          cnt_d   = '0;
          state_d = rx_s ? StIdle : StData;
        end
      end
      StData: begin
        if (bit_tick) begin
          shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
          if (idx_q == IdxLast) begin
            state_d = (PARITY_EN != 0) ? StParity : StStop;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      StParity: begin
        if (bit_tick) begin
          perr_d  = (^shreg_q) ^ rx_s ^ ParOdd;
          state_d = StStop;
        end
      end
      StStop: begin
        if (bit_tick) begin
          ferr_d = ferr_q | ~rx_s;
          if (stop_q == StopLast) begin
            push    = 1'b1;
            state_d = StIdle;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    push_entry = {perr_q, ferr_d, shreg_q};
  end

  // A push into a full FIFO is only lost when no pop frees a slot that cycle.
  always_comb begin
    ovr_d = ovr_q;
    if (push && fifo_full && !clr_rdy_i) begin
      ovr_d = 1'b1;
    end else if (clr_ovr_i) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      shreg_q <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      shreg_q <= shreg_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  uart_rx_fifo #(
    .WIDTH (EntW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (clr_rdy_i),
    .din_i   (push_entry),
    .dout_o  (head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign {parity_err_o, frame_err_o, rx_data_o} = head;
  assign rdy_o     = ~fifo_empty;
  assign overrun_o = ovr_q;
  assign busy_o    = (state_q != StIdle);

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised, buffered UART receiver; next generation of the single-byte fixed-rate receiver.
- Configurable bit time, data width, parity and stop-bit count.
- 2-flop input synchroniser with false-start rejection.
- Per-character parity/framing error flags.
- Small first-word-fall-through receive FIFO with sticky overrun, so the consumer need not service every character within one frame time.
- Sits between the board RX pin and the command/packet layer.

Parameters:
CLKS_PER_BIT, 868, clk cycles per bit; must be even and >= 8.
DATA_BITS, 8, data bits per character, 5..9, LSB first.
PARITY_EN, 0, 1 = one parity bit follows data.
PARITY_ODD, 0, 1 = odd parity, 0 = even; ignored when PARITY_EN = 0.
STOP_BITS, 1, 1 or 2 stop bits checked.
FIFO_DEPTH, 4, entries in the receive FIFO; power of 2, >= 2.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
RX  input  1  serial line, idle high, asynchronous to clk
clr_rdy  input  1  pop the head entry; ignored when rdy = 0
clr_ovr  input  1  clear the sticky overrun flag
rx_data  output  DATA_BITS  head-of-FIFO data, valid when rdy = 1
parity_err  output  1  head entry had a parity mismatch; valid when rdy = 1
frame_err  output  1  head entry had a stop bit sampled 0; valid when rdy = 1
rdy  output  1  FIFO not empty
overrun  output  1  sticky: a character was dropped because the FIFO was full
busy  output  1  FSM not in IDLE

Behaviour:
Reset:
- All outputs 0; FIFO empty.
- Synchroniser flops reset to 1 (line idle), so reset never produces a start.
- FSM returns to IDLE; a partially received character is discarded.

Synchroniser:
- RX passes through 2 flops; only rx_s (the second flop) is used.

Bit counter:
- Counts 0..CLKS_PER_BIT-1, then wraps to 0.
- Cleared on every state entry.
- Width is $clog2(CLKS_PER_BIT).

FSM states and transitions:
- IDLE: on rx_s == 0 -> START, counter cleared.
- START: at count CLKS_PER_BIT/2-1, sample rx_s.
  - Sample 1: false start -> IDLE, nothing pushed.
  - Sample 0: -> DATA, counter cleared. Every later sample is therefore mid-bit.
- DATA: at count CLKS_PER_BIT-1, shift rx_s into the MSB of the shift register (LSB-first assembly) and increment the bit index.
  - After DATA_BITS samples -> PARITY if PARITY_EN, else STOP.
- PARITY: one sample at count CLKS_PER_BIT-1.
  - perr = XOR(data bits, sampled bit) XOR PARITY_ODD; the result must be 0.
  - Then -> STOP.
- STOP: STOP_BITS samples, each at count CLKS_PER_BIT-1.
  - ferr = OR of (sample == 0) across all stop samples.
  - On the final sample, push {perr, ferr, data} and go to IDLE in the same cycle. The next start edge can then be detected half a bit early, which gives full tolerance of back-to-back characters.
- Break (all zeros, ferr = 1) is pushed like any other character.

Push/pop timing:
- rdy rises 1 clk after the push cycle.
- With default parameters, the push occurs 2 + 434 + 9*868 clks after RX falls.
- Pop: clr_rdy with rdy = 1 advances the head. rx_data/err outputs show the next entry (or hold stale data if empty) the following cycle.

FIFO corner cases:
- Full, push only: the character is dropped, FIFO contents are unchanged, and overrun is set the next cycle.
- Full, simultaneous push and pop: both take effect; no overrun.
- Empty, simultaneous push and pop: the pop is ignored and the push takes effect.

overrun flag:
- Stays set until clr_ovr.
- clr_ovr in the same cycle as a new overrun event: set wins.

Pointers and count:
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally.
- A separate count of log2(FIFO_DEPTH)+1 bits distinguishes full from empty.

RX glitch mid-character:
- No resynchronisation. The FSM completes the frame, and the errors are reported through the flags.

Decomposition:
Package uart_pkg:
- rx_state_t enum (IDLE, START, DATA, PARITY, STOP).
- SYNC_STAGES = 2.
- Helper function clog2-based width constants.

Sub-module uart_rx_fifo:
- Parametrised by WIDTH and DEPTH.
- Ports: push, pop, din, dout, empty, full.
- Instantiated with WIDTH = DATA_BITS+2.
- The FSM, synchroniser, sampling and error logic stay in uart_rx_param.

Test Plan:
Use CLKS_PER_BIT=16 for all scenarios.
1. Defaults (8N1): send 0xA5 -> exactly one push; rdy = 1; rx_data = 0xA5, parity_err = 0, frame_err = 0; clr_rdy -> rdy = 0 next cycle.
2. False start: RX low for 6 clks, then high -> busy returns 0, rdy stays 0, no push.
3. PARITY_EN=1, PARITY_ODD=0:
   - Send 0x03 with parity bit 0 -> parity_err = 0.
   - Send 0x03 with parity bit 1 -> parity_err = 1, rx_data = 0x03.
4. STOP_BITS=2, second stop bit driven 0 -> frame_err = 1. Also send a break (RX low for 12 bit times) -> entry 0x00 with frame_err = 1.
5. FIFO_DEPTH=4:
   - Send 5 characters (0x11..0x55) back-to-back with no pops -> overrun = 1; pops return 0x11, 0x22, 0x33, 0x44, then rdy = 0.
   - clr_ovr -> overrun = 0.
   - Also pop in the push cycle while full -> no overrun.
6. Assert rst_n low mid-DATA -> all outputs 0, FIFO empty. A subsequent clean 0x5A frame is received correctly.
